// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor: one decimal digit per clock, LSD first,
// with 10's-complement subtract and an invalid-digit flag.
module bcd_serial_adder #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                cout,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   acc;
    logic           sub_reg;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic [3:0]     bd;
    logic [4:0]     s;
    logic [3:0]     dig;
    logic           dig_carry;
    logic [W-1:0]   acc_next;
    logic           any_bad;

    // Operands shift right each cycle, so the digit in flight is always in bits [3:0].
    always_comb begin
        bd        = sub_reg ? (4'd9 - b_reg[3:0]) : b_reg[3:0];
        s         = {1'b0, a_reg[3:0]} + {1'b0, bd} + {4'b0000, carry};
        dig       = s[3:0];
        dig_carry = 1'b0;
        if (s > 5'd9) begin
            dig       = s[3:0] + 4'd6;
            dig_carry = 1'b1;
        end
        acc_next = (acc >> 4) | (W'(dig) << (W - 4));
    end

    always_comb begin
        any_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) begin
                any_bad = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            sub_reg   <= 1'b0;
            carry     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        carry     <= sub ? 1'b1 : cin;
                        err       <= any_bad;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b0;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    a_reg <= a_reg >> 4;
                    b_reg <= b_reg >> 4;
                    carry <= dig_carry;
                    acc   <= acc_next;
                    cnt   <= cnt + 1'b1;
                    // The result register only changes when the last digit lands.
                    if (cnt == CW'(DIGITS - 1)) begin
                        sum       <= acc_next;
                        cout      <= dig_carry;
                        out_valid <= 1'b1;
                        cnt       <= '0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder: directed cases plus randomized operands
// compared against a decimal-arithmetic reference model.
module tb_bcd_serial_adder;

    localparam int D = 2;
    localparam int W = 4 * D;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks;
    int failures;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int           t;
        r = '0;
        t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal model: add wraps mod 10^D; subtract gives 10's complement when A<B.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic mcin, input logic msub,
                                  output logic [W-1:0] esum, output logic ecout);
        int av, bv, m, r;
        av = bcd2int(ma);
        bv = bcd2int(mb);
        m  = pow10(D);
        if (msub) begin
            ecout = (av >= bv);
            r     = (av >= bv) ? (av - bv) : (m - (bv - av));
        end else begin
            r     = av + bv + int'(mcin);
            ecout = (r >= m);
            r     = r % m;
        end
        esum = int2bcd(r);
    endfunction

    // Drives one transaction and returns the result plus accept-to-valid latency.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tcin, input logic tsub, input int hold,
                          output logic [W-1:0] rs, output logic rc, output logic re,
                          output int lat, output bit ok);
        int n;
        ok  = 1'b1;
        lat = 0;
        n   = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) ok = 1'b0;
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) ok = 1'b0;
        rs = sum;
        rc = cout;
        re = err;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, err} !== {1'b1, 1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_state got rdy=%b ov=%b sum=%h c=%b e=%b want rdy=1 ov=0 sum=0 c=0 e=0",
                     in_ready, out_valid, sum, cout, err);
        end
    endtask

    task automatic test_basic_add;
        logic [W-1:0] rs; logic rc, re; int lat; bit ok;
        run_op(8'h45, 8'h78, 1'b0, 1'b0, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc, re} !== {8'h23, 1'b1, 1'b0}) begin
            failures++;
            $display("[TB] FAIL add_45_78 got sum=%h c=%b e=%b ok=%0d want sum=23 c=1 e=0", rs, rc, re, ok);
        end
        checks++;
        if (lat !== D) begin
            failures++;
            $display("[TB] FAIL latency got %0d want %0d", lat, D);
        end
    endtask

    task automatic test_add_edges;
        logic [W-1:0] rs; logic rc, re; int lat; bit ok;
        run_op(8'h99, 8'h99, 1'b1, 1'b0, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc} !== {8'h99, 1'b1}) begin
            failures++;
            $display("[TB] FAIL add_99_99_c1 got sum=%h c=%b want sum=99 c=1", rs, rc);
        end
        run_op(8'h00, 8'h00, 1'b0, 1'b0, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc} !== {8'h00, 1'b0}) begin
            failures++;
            $display("[TB] FAIL add_00_00 got sum=%h c=%b want sum=00 c=0", rs, rc);
        end
    endtask

    task automatic test_sub;
        logic [W-1:0] rs; logic rc, re; int lat; bit ok;
        run_op(8'h52, 8'h17, 1'b0, 1'b1, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc} !== {8'h35, 1'b1}) begin
            failures++;
            $display("[TB] FAIL sub_52_17 got sum=%h c=%b want sum=35 c=1", rs, rc);
        end
        run_op(8'h17, 8'h52, 1'b0, 1'b1, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc} !== {8'h65, 1'b0}) begin
            failures++;
            $display("[TB] FAIL sub_17_52 got sum=%h c=%b want sum=65 c=0", rs, rc);
        end
        run_op(8'h52, 8'h17, 1'b1, 1'b1, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc} !== {8'h35, 1'b1}) begin
            failures++;
            $display("[TB] FAIL sub_cin_ignored got sum=%h c=%b want sum=35 c=1", rs, rc);
        end
    endtask

    task automatic test_err;
        logic [W-1:0] rs; logic rc, re; int lat; bit ok;
        run_op(8'h3A, 8'h01, 1'b0, 1'b0, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || re !== 1'b1) begin
            failures++;
            $display("[TB] FAIL err_flag got e=%b ok=%0d want e=1", re, ok);
        end
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, re} !== {8'h46, 1'b0}) begin
            failures++;
            $display("[TB] FAIL err_clear got sum=%h e=%b want sum=46 e=0", rs, re);
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] s0;
        logic         c0;
        int           n;
        a = 8'h27; b = 8'h38; cin = 1'b1; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        s0 = sum;
        c0 = cout;
        checks++;
        if (!out_valid || {s0, c0} !== {8'h66, 1'b0}) begin
            failures++;
            $display("[TB] FAIL bp_result got ov=%b sum=%h c=%b want ov=1 sum=66 c=0", out_valid, s0, c0);
        end
        for (int i = 0; i < 5; i++) begin
            a = 8'(8'h11 * (i + 1)); b = 8'h22; in_valid = i[0];
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, sum, cout} !== {1'b1, 1'b0, 8'h66, 1'b0}) begin
                failures++;
                $display("[TB] FAIL bp_hold cyc=%0d got ov=%b rdy=%b sum=%h c=%b want ov=1 rdy=0 sum=66 c=0",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready, sum} !== {1'b0, 1'b1, 8'h66}) begin
            failures++;
            $display("[TB] FAIL bp_release got ov=%b rdy=%b sum=%h want ov=0 rdy=1 sum=66",
                     out_valid, in_ready, sum);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] rs; logic rc, re; int lat; bit ok;
        a = 8'h58; b = 8'h19; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, sum, cout, err} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL reset_mid got ov=%b sum=%h c=%b e=%b want ov=0 sum=0 c=0 e=0",
                     out_valid, sum, cout, err);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (D + 2) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_no_result got ov=%b want ov=0", out_valid);
            end
        end
        run_op(8'h58, 8'h19, 1'b0, 1'b0, 0, rs, rc, re, lat, ok);
        checks++;
        if (!ok || {rs, rc, re} !== {8'h77, 1'b0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL after_reset got sum=%h c=%b e=%b want sum=77 c=0 e=0", rs, rc, re);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] ra, rb, rs, esum;
        logic         rcin, rsub, rc, re, ecout, ebad;
        int           lat;
        bit           ok;
        for (int t = 0; t < 60; t++) begin
            ebad = 1'b0;
            for (int i = 0; i < D; i++) begin
                if ($urandom_range(0, 9) == 0) begin
                    ra[4*i +: 4] = 4'($urandom_range(10, 15));
                    ebad = 1'b1;
                end else begin
                    ra[4*i +: 4] = 4'($urandom_range(0, 9));
                end
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            rcin = 1'($urandom_range(0, 1));
            rsub = 1'($urandom_range(0, 1));
            run_op(ra, rb, rcin, rsub, $urandom_range(0, 2), rs, rc, re, lat, ok);
            checks++;
            if (!ok || re !== ebad || lat !== D) begin
                failures++;
                $display("[TB] FAIL rand_flags a=%h b=%h got e=%b lat=%0d ok=%0d want e=%b lat=%0d",
                         ra, rb, re, lat, ok, ebad, D);
            end
            if (!ebad) begin
                model(ra, rb, rcin, rsub, esum, ecout);
                checks++;
                if ({rs, rc} !== {esum, ecout}) begin
                    failures++;
                    $display("[TB] FAIL rand_result a=%h b=%h cin=%b sub=%b got sum=%h c=%b want sum=%h c=%b",
                             ra, rb, rcin, rsub, rs, rc, esum, ecout);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic_add();
        test_add_edges();
        test_sub();
        test_err();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
